// File: rtl/fround_pipe.sv
// fround_pipe: two-stage IEEE-754 round-to-integral (RNE/RTZ/RDN/RUP), result kept in float format.
// S1 decides the increment and S2 applies it; valid/ready with no bubble. FROUND_INEXACT_EN adds out_inexact.
module fround_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [1:0]       in_rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_y,
  output logic [TAG_W-1:0] out_tag
`ifdef FROUND_INEXACT_EN
  ,
  output logic             out_inexact
`endif
);

  localparam int M      = EXP_W + MAN_W;
  localparam int CLOG_M = $clog2(MAN_W + 1);
  localparam int CW     = ((EXP_W > CLOG_M) ? EXP_W : CLOG_M) + 2;
  localparam int BIAS_I = (1 << (EXP_W - 1)) - 1;

  localparam logic [CW-1:0]    BIAS    = CW'(BIAS_I);
  localparam logic [CW-1:0]    INT_E   = CW'(BIAS_I + MAN_W);
  localparam logic [MAN_W:0]   ONE_L   = (MAN_W+1)'(1);
  localparam logic [MAN_W-1:0] ONE_F   = MAN_W'(1);
  localparam logic [M-1:0]     ONE_MAG = {EXP_W'(BIAS_I), {MAN_W{1'b0}}};

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RDN = 2'b10,
    RM_RUP = 2'b11
  } rm_e;

  // Operand fields
  logic             sgn;
  logic [EXP_W-1:0] ex;
  logic [MAN_W-1:0] fr;

  assign sgn = in_x[W-1];
  assign ex  = in_x[W-2:MAN_W];
  assign fr  = in_x[MAN_W-1:0];

  // S1 combinational: classify, mask, and choose the increment
  logic [CW-1:0]    ex_w;
  logic [CW-1:0]    frac_cnt;
  logic [MAN_W:0]   lsb_one;
  logic [MAN_W-1:0] mask;
  logic [MAN_W-1:0] half;
  logic [MAN_W-1:0] disc;
  logic             rbit;
  logic             sticky;
  logic             klsb;
  logic             nz;
  logic             inc;
  logic             to_one;
  logic [M-1:0]     mag_d;
  logic [M-1:0]     add_d;
  logic             inex_d;

  always_comb begin
    ex_w     = CW'(ex);
    frac_cnt = INT_E - ex_w;
    lsb_one  = ONE_L << frac_cnt;
    mask     = lsb_one[MAN_W-1:0] - ONE_F;
    half     = lsb_one[MAN_W:1];
    disc     = fr & mask;
    rbit     = |(fr & half);
    sticky   = |(fr & mask & ~half);
    // kept LSB may be the hidden bit when only the integer 1 survives
    klsb     = |({1'b1, fr} & lsb_one);
    nz       = (ex != '0) || (fr != '0);
    inc      = 1'b0;
    to_one   = 1'b0;
    mag_d    = in_x[M-1:0];
    add_d    = '0;
    inex_d   = 1'b0;

    if (ex_w >= INT_E) begin
      mag_d = in_x[M-1:0];
    end else if (ex_w >= BIAS) begin
      case (rm_e'(in_rm))
        RM_RNE:  inc = rbit && (sticky || klsb);
        RM_RTZ:  inc = 1'b0;
        RM_RDN:  inc = sgn && (disc != '0);
        RM_RUP:  inc = !sgn && (disc != '0);
        default: inc = 1'b0;
      endcase
      mag_d  = {ex, fr & ~mask};
      add_d  = inc ? M'(lsb_one) : '0;
      inex_d = (disc != '0);
    end else begin
      case (rm_e'(in_rm))
        RM_RNE:  to_one = (ex_w == BIAS - CW'(1)) && (fr != '0);
        RM_RTZ:  to_one = 1'b0;
        RM_RDN:  to_one = sgn && nz;
        RM_RUP:  to_one = !sgn && nz;
        default: to_one = 1'b0;
      endcase
      mag_d  = to_one ? ONE_MAG : '0;
      inex_d = nz;
    end
  end

  // Pipeline control
  logic s1_load;
  logic s2_load;
  logic v1;
  logic v2;

  assign s2_load  = !v2 || out_ready;
  assign s1_load  = !v1 || s2_load;
  assign in_ready = s1_load;

  logic             sgn1;
  logic [M-1:0]     mag1;
  logic [M-1:0]     add1;
  logic [TAG_W-1:0] tag1;
  logic             inex1;
  logic [W-1:0]     y2;
  logic [TAG_W-1:0] tag2;
  logic             inex2;

  // Carry out of the fraction ripples into the exponent in the same add
  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      sgn1  <= 1'b0;
      mag1  <= '0;
      add1  <= '0;
      tag1  <= '0;
      inex1 <= 1'b0;
      y2    <= '0;
      tag2  <= '0;
      inex2 <= 1'b0;
    end else begin
      if (s1_load) begin
        v1 <= in_valid;
      end
      if (s1_load && in_valid) begin
        sgn1  <= sgn;
        mag1  <= mag_d;
        add1  <= add_d;
        tag1  <= in_tag;
        inex1 <= inex_d;
      end
      if (s2_load) begin
        v2 <= v1;
      end
      if (s2_load && v1) begin
        y2    <= {sgn1, mag1 + add1};
        tag2  <= tag1;
        inex2 <= inex1;
      end
    end
  end

  assign out_valid = v2;
  assign out_y     = y2;
  assign out_tag   = tag2;

`ifdef FROUND_INEXACT_EN
  assign out_inexact = inex2;
`else
  logic unused_inex;
  assign unused_inex = inex2;
`endif

endmodule

// File: tb/tb_fround_pipe.sv
// Scoreboard bench for fround_pipe (FP32): driver pushes expectations, negedge monitor pops and compares.
module tb_fround_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = '0;
  logic [1:0]  in_rm = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_y;
  logic [3:0]  out_tag;
`ifdef FROUND_INEXACT_EN
  logic        out_inexact;
`endif

  fround_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_rm     (in_rm),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_tag   (out_tag)
`ifdef FROUND_INEXACT_EN
    ,
    .out_inexact (out_inexact)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    logic [3:0]  tag;
    logic        inex;
    int          acc_cyc;
    bit          lat;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          dir_en = 1'b0;
  logic [31:0] dir_y = '0;
  logic        dir_inex = 1'b0;
  bit          lat_chk = 1'b0;
  int          rdy_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference: value as integer part + remainder, rounded arithmetically, then re-encoded
  function automatic logic [32:0] ref_round(input logic [31:0] x, input logic [1:0] rm);
    logic        s;
    int          e;
    int          sh;
    int          p;
    longint      sig;
    longint      ip;
    longint      rem;
    longint      half;
    longint      n;
    longint      frac;
    logic [31:0] y;
    s = x[31];
    e = int'(x[30:23]);
    if (e >= 150) return {1'b0, x};
    sig = (e == 0) ? longint'(x[22:0]) : (longint'(x[22:0]) + (64'sd1 <<< 23));
    sh  = 150 - ((e == 0) ? 1 : e);
    if (sh > 40) sh = 40;
    ip   = sig >>> sh;
    rem  = sig & ((64'sd1 <<< sh) - 1);
    half = 64'sd1 <<< (sh - 1);
    case (rm)
      2'd0:    n = ip + (((rem > half) || ((rem == half) && ip[0])) ? 1 : 0);
      2'd1:    n = ip;
      2'd2:    n = ip + ((s && rem != 0) ? 1 : 0);
      default: n = ip + ((!s && rem != 0) ? 1 : 0);
    endcase
    if (n == 0) begin
      y = {s, 31'b0};
    end else begin
      p = 0;
      for (int i = 0; i < 40; i++) if (n[i]) p = i;
      frac = (p <= 23) ? (n <<< (23 - p)) : (n >>> (p - 23));
      y = {s, 8'(127 + p), 23'(frac)};
    end
    return {rem != 0, y};
  endfunction

  function automatic logic [31:0] rand_x();
    int          k;
    logic [22:0] f;
    logic [31:0] x;
    case ($urandom_range(0, 3))
      0: x = $urandom;
      1: x = {1'($urandom), 8'($urandom_range(118, 155)), 23'($urandom)};
      2: begin
        case ($urandom_range(0, 7))
          0:       x = 32'h7F800000;
          1:       x = 32'hFF800000;
          2:       x = 32'h7FC00123;
          3:       x = 32'h00000000;
          4:       x = 32'h80000000;
          5:       x = {1'($urandom), 8'h00, 23'($urandom)};
          6:       x = 32'h3F000000;
          default: x = 32'hBF000000;
        endcase
      end
      default: begin
        // exact ties at every fractional position
        k = $urandom_range(0, 22);
        f = 23'(32'($urandom) << (23 - k)) | 23'(32'h1 << (22 - k));
        x = {1'($urandom), 8'(127 + k), f};
      end
    endcase
    return x;
  endfunction

  // Cycle counter and out_ready driver
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    else               out_ready = (rdy_mode == 0);
  end

  // Monitor: push on accept, pop and compare on output transfer, watch stall stability
  initial begin : monitor
    exp_t        e;
    logic [32:0] r;
    bit          prev_stall;
    logic [31:0] prev_y;
    logic [3:0]  prev_tag;
    prev_stall = 1'b0;
    prev_y     = '0;
    prev_tag   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && out_valid) begin
          chk("stall_y", out_y, prev_y);
          chk("stall_tag", 32'(out_tag), 32'(prev_tag));
        end
        prev_stall = out_valid && !out_ready;
        prev_y     = out_y;
        prev_tag   = out_tag;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got y=%h tag=%0d, required no result", out_y, out_tag);
          end else begin
            e = q.pop_front();
            chk("y", out_y, e.y);
            chk("tag", 32'(out_tag), 32'(e.tag));
`ifdef FROUND_INEXACT_EN
            chk("inexact", 32'(out_inexact), 32'(e.inex));
`endif
            if (e.lat) chk("latency", 32'(cyc - e.acc_cyc), 32'd2);
          end
        end
        if (in_valid && in_ready) begin
          r         = ref_round(in_x, in_rm);
          e.y       = dir_en ? dir_y : r[31:0];
          e.inex    = dir_en ? dir_inex : r[32];
          e.tag     = in_tag;
          e.acc_cyc = cyc;
          e.lat     = lat_chk;
          q.push_back(e);
        end
      end
    end
  end

  task automatic set_mode(input int m);
    rdy_mode  = m;
    out_ready = (m != 2);
  endtask

  task automatic send(input logic [31:0] x, input logic [1:0] rm, input logic [3:0] tag);
    int n;
    n        = 0;
    in_x     = x;
    in_rm    = rm;
    in_tag   = tag;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_dir(input logic [31:0] x, input logic [1:0] rm, input logic [3:0] tag,
                          input logic [31:0] y, input logic inex);
    dir_en   = 1'b1;
    dir_y    = y;
    dir_inex = inex;
    send(x, rm, tag);
    dir_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [1:0] RNE = 2'd0, RTZ = 2'd1, RDN = 2'd2, RUP = 2'd3;

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_y", out_y, 32'd0);
    chk("reset_out_tag", 32'(out_tag), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef FROUND_INEXACT_EN
    chk("reset_inexact", 32'(out_inexact), 32'd0);
`endif
    @(posedge clk);
    #1;

    // Directed vectors, unstalled, with latency checked
    lat_chk = 1'b1;
    send_dir(32'h3FC00000, RNE, 4'd1,  32'h40000000, 1'b1);
    send_dir(32'h40200000, RNE, 4'd2,  32'h40000000, 1'b1);
    send_dir(32'h3F000000, RNE, 4'd3,  32'h00000000, 1'b1);
    send_dir(32'hBE99999A, RDN, 4'd4,  32'hBF800000, 1'b1);
    send_dir(32'hBE99999A, RUP, 4'd5,  32'h80000000, 1'b1);
    send_dir(32'hBE99999A, RTZ, 4'd6,  32'h80000000, 1'b1);
    send_dir(32'h7FC00001, RNE, 4'd7,  32'h7FC00001, 1'b0);
    send_dir(32'hFF800000, RDN, 4'd8,  32'hFF800000, 1'b0);
    send_dir(32'h4B000001, RUP, 4'd9,  32'h4B000001, 1'b0);
    send_dir(32'h3FE00000, RUP, 4'd10, 32'h40000000, 1'b1);
    send_dir(32'hBFE00000, RDN, 4'd11, 32'hC0000000, 1'b1);
    send_dir(32'hBF000000, RNE, 4'd12, 32'h80000000, 1'b1);
    send_dir(32'h3F400000, RNE, 4'd13, 32'h3F800000, 1'b1);
    send_dir(32'h40400000, RUP, 4'd14, 32'h40400000, 1'b0);
    idle(4);
    lat_chk = 1'b0;

    // Backpressure: two accepts fill the pipe, then in_ready drops
    set_mode(2);
    send(32'h3FC00000, RNE, 4'd0);
    send(32'h40200000, RNE, 4'd1);
    in_x   = 32'h3FE00000;
    in_rm  = RUP;
    in_tag = 4'd2;
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_accepts", 32'(q.size()), 32'd2);
    repeat (4) @(posedge clk);
    #1;
    set_mode(0);
    send(32'h3FE00000, RUP, 4'd2);
    send(32'hBFE00000, RDN, 4'd3);
    idle(6);

    // Reset with both stages occupied
    set_mode(2);
    send(32'h40A00000, RNE, 4'd5);
    send(32'h40E00000, RNE, 4'd6);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    set_mode(0);
    idle(8);

    // Random operands under random backpressure
    set_mode(1);
    for (int i = 0; i < 300; i++) send(rand_x(), 2'($urandom), 4'(i));
    idle(2);
    set_mode(0);
    idle(4);

    // Random operands, full throughput, latency checked
    lat_chk = 1'b1;
    for (int i = 0; i < 150; i++) send(rand_x(), 2'($urandom), 4'(i));
    idle(4);
    lat_chk = 1'b0;

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fround_pipe.md
Name: fround_pipe

Overview:
- Pipelined, parametrised IEEE-754 round-to-integral unit. Output stays in float format.
- Generalises the single-mode combinational floor in three ways:
  - runtime-selectable rounding mode: nearest-even, toward zero, down (floor), up (ceil);
  - parametrised exponent and mantissa widths;
  - registered two-stage datapath with valid/ready handshake and a transaction tag.
- Sits in the FPU next to the other conversion ops and is fed by the FPU issue stage.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, mantissa (fraction) field width; word width W = 1+EXP_W+MAN_W.
- TAG_W, 4, width of the opaque tag carried alongside each operand.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high. The block has one clock, synchronous active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  unit can accept an operand this cycle.
- in_x  in  W  operand.
- in_rm  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN (floor), 11 RUP (ceil).
- in_tag  in  TAG_W  tag, returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_y  out  W  rounded result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Pipeline: stages S1 (decode, mask, round-increment decision) and S2 (add, renormalise). Each stage has its own valid bit.
- Stage advance:
  - S2 loads when !v2 || out_ready.
  - S1 loads when !v1 || S2 loads.
  - in_ready = !v1 || S2 loads. This is combinational from out_ready; there is no bubble.
- Latency: 2 cycles from accepted input to out_valid with no stall. Throughput is 1/cycle.
- Handshake:
  - A transfer occurs on valid && ready.
  - out_y and out_tag hold stable while out_valid && !out_ready.
  - in_x, in_rm and in_tag are sampled only on transfer.
- Reset: v1 = v2 = 0 and out_valid = 0. out_y and out_tag reset to 0. An operand in flight at reset is discarded; no result emerges.
- Definitions: bias B = 2^(EXP_W-1)-1; e = exponent field; frac = MAN_W-(e-B) fractional bit count when e ≥ B.
- e ≥ B+MAN_W (already integral, including Inf and NaN): out_y = in_x bit-exact. NaN payload and sign are preserved.
- B ≤ e < B+MAN_W:
  - Clear the low frac bits of the significand.
  - Set inc = 1 per mode:
    - RTZ: never.
    - RDN: sign && discarded bits ≠ 0.
    - RUP: !sign && discarded bits ≠ 0.
    - RNE: round bit && (sticky || LSB of kept part).
  - When inc = 1, add 1 at kept LSB. On significand carry-out, increment e and zero the fraction (e.g. 1.75 RUP → 2.0).
  - Exponent overflow is impossible in this range.
- e < B (|x| < 1, including subnormals and zero): result is ±0 or ±1.0 with the sign kept.
  - ±1.0 when:
    - RDN and negative nonzero;
    - RUP and positive nonzero;
    - RNE and e == B-1 with fraction ≠ 0 (|x| > 0.5).
  - |x| == 0.5 under RNE → ±0.
  - Otherwise ±0.
- Sign of the result always equals the input sign (−0.3 RUP → −0.0).
- Simultaneous accept at S1 and drain at S2 in the same cycle is legal and loses nothing.

Optional Feature:
- Macro FROUND_INEXACT_EN.
- Defined:
  - Adds output port out_inexact (1 bit), pipelined alongside out_y.
  - out_inexact = 1 iff any discarded bit was nonzero and the input is not Inf or NaN.
  - Reset value 0; holds stable under stall like out_y.
- Undefined: port absent; no flag logic.

Test Plan:
- FP32, RNE:
  - 0x3FC00000 (1.5) → 0x40000000;
  - 0x40200000 (2.5) → 0x40000000;
  - 0x3F000000 (0.5) → 0x00000000;
  - each out_valid exactly 2 cycles after accept, tags echoed.
- FP32 0xBE99999A (−0.3):
  - RDN → 0xBF800000;
  - RUP → 0x80000000;
  - RTZ → 0x80000000;
  - with FROUND_INEXACT_EN, out_inexact = 1 in all three.
- Pass-through:
  - 0x7FC00001 (NaN) → 0x7FC00001;
  - 0xFF800000 (−Inf) → 0xFF800000;
  - 0x4B000001 → 0x4B000001;
  - out_inexact = 0.
- Carry: 0x3FE00000 (1.75) RUP → 0x40000000; 0xBFE00000 (−1.75) RDN → 0xC0000000.
- Backpressure:
  - Stream 4 tagged operands (tags 0–3) back-to-back.
  - Hold out_ready = 0 for 5 cycles, then release.
  - in_ready drops after 2 accepts.
  - out_y and out_tag stay stable while stalled.
  - Results emerge in order 0–3 with none lost or duplicated.
- Reset mid-operation: assert rst with both stages valid → out_valid = 0 the next cycle, in_ready = 1, and no stale result appears after release.
